demorgan_checker: RTL and testbench

Self-contained sequential exerciser for the two-input De Morgan gate block. It drives the block's A/B inputs and consumes its eight outputs. On a start pulse it sweeps all four input vectors, waits a settle time, and checks every output against the golden value and the two De Morgan identities. It accumulates sticky error status and reports pass/fail with a done pulse, for use in lab/FPGA self-test of the gate-level design.

---
 rtl/demorgan_pkg.sv | 40 ++++
 rtl/demorgan_if.sv | 29 ++
 rtl/demorgan_golden.sv | 17 +
 rtl/demorgan_checker.sv | 195 +++++++++++++++++++
 tb/tb_demorgan_checker.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/demorgan_pkg.sv
// Shared types and golden model for the De Morgan gate-block exerciser.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package demorgan_pkg;

   // Exerciser sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   // Bit positions of each gate output inside err_mask and the golden vector
   localparam int ERR_NA      = 0;
   localparam int ERR_NB      = 1;
   localparam int ERR_AB      = 2;
   localparam int ERR_AORB    = 3;
   localparam int ERR_NANDNB  = 4;
   localparam int ERR_NAORB   = 5;
   localparam int ERR_NAORNB  = 6;
   localparam int ERR_NAB     = 7;

   // Golden outputs of the gate block for one {A,B} input pair
   function automatic logic [7:0] expected_outputs(input logic a, input logic b);
      logic [7:0] v;
      v              = '0;
      v[ERR_NA]      = ~a;
      v[ERR_NB]      = ~b;
      v[ERR_AB]      = a & b;
      v[ERR_AORB]    = a | b;
      v[ERR_NANDNB]  = ~a & ~b;
      v[ERR_NAORB]   = ~(a | b);
      v[ERR_NAORNB]  = ~a | ~b;
      v[ERR_NAB]     = ~(a & b);
      return v;
   endfunction

endpackage

// File: rtl/demorgan_if.sv
// Signal bundle between the exerciser and the two-input De Morgan gate block.
// Latency: n/a (wires only).
// Backpressure: none; the gate block is purely combinational.
interface demorgan_if;

   logic A;
   logic B;
   logic nA;
   logic nB;
   logic AB;
   logic AorB;
   logic nAandnB;
   logic nAorB;
   logic nAornB;
   logic nAB;

   // Exerciser side: drives stimulus, observes the eight gate outputs
   modport master (
      output A, B,
      input  nA, nB, AB, AorB, nAandnB, nAorB, nAornB, nAB
   );

   // Gate-block side: consumes stimulus, produces the eight outputs
   modport slave (
      input  A, B,
      output nA, nB, AB, AorB, nAandnB, nAorB, nAornB, nAB
   );

endinterface

// File: rtl/demorgan_golden.sv
// Golden model of the gate block: {A,B} -> 8-bit expected vector in err_mask order.
// Latency: combinational, zero cycles.
// Backpressure: none.
module demorgan_golden
   import demorgan_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   output logic [7:0] exp_o
);

   // Expected outputs recomputed whenever the stimulus changes
   always_comb begin
      exp_o = expected_outputs(a_i, b_i);
   end

endmodule

// File: rtl/demorgan_checker.sv
// Sweeps {A,B} over 00..11 for PASSES runs, checks gate outputs and De Morgan identities, sticky status.
// Latency: done at start+1+PASSES*4*(SETTLE_CYCLES+2) cycles; each vector is DRIVE, SETTLE_CYCLES waits, CHECK.
// Backpressure: none; start is only honoured in IDLE, requests while busy or in DONE are dropped.
module demorgan_checker
   import demorgan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   demorgan_if.master  gate_if,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  err_mask,
   output logic [3:0]  err_count,
   output logic [1:0]  first_fail,
   output logic        fail_seen,
   output logic        ident_err
);

   // Settle counter reload: the counter counts down to zero, so it holds SETTLE_CYCLES cycles
   localparam logic [3:0] SETTLE_LD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] PASS_LAST = 3'(PASSES - 1);

   state_t      state_q;
   logic [1:0]  vec_q;
   logic [2:0]  pass_cnt_q;
   logic [3:0]  settle_q;
   logic        a_q;
   logic        b_q;
   logic        busy_q;
   logic        done_q;
   logic        pass_q;
   logic [7:0]  err_mask_q;
   logic [3:0]  err_count_q;
   logic [1:0]  first_fail_q;
   logic        fail_seen_q;
   logic        ident_err_q;

   logic [7:0]  obs_vec;
   logic [7:0]  exp_vec;
   logic [7:0]  mism_vec;
   logic        any_mism;
   logic        ident_bad;
   logic [1:0]  vec_nxt;

   logic [7:0]  err_mask_d;
   logic [3:0]  err_count_d;
   logic [1:0]  first_fail_d;
   logic        fail_seen_d;
   logic        ident_err_d;

   demorgan_golden u_golden (
      .a_i   (a_q),
      .b_i   (b_q),
      .exp_o (exp_vec)
   );

   // Gather observed outputs into the same bit order as the golden vector
   always_comb begin
      obs_vec             = '0;
      obs_vec[ERR_NA]     = gate_if.nA;
      obs_vec[ERR_NB]     = gate_if.nB;
      obs_vec[ERR_AB]     = gate_if.AB;
      obs_vec[ERR_AORB]   = gate_if.AorB;
      obs_vec[ERR_NANDNB] = gate_if.nAandnB;
      obs_vec[ERR_NAORB]  = gate_if.nAorB;
      obs_vec[ERR_NAORNB] = gate_if.nAornB;
      obs_vec[ERR_NAB]    = gate_if.nAB;
   end

   // Status as it would stand after checking the current vector; committed only in CHECK
   always_comb begin
      mism_vec  = obs_vec ^ exp_vec;
      any_mism  = |mism_vec;
      // Identities compare observed outputs against each other, independent of the golden model
      ident_bad = (obs_vec[ERR_NANDNB] != obs_vec[ERR_NAORB]) |
                  (obs_vec[ERR_NAORNB] != obs_vec[ERR_NAB]);
      vec_nxt   = vec_q + 2'd1;

      err_mask_d   = err_mask_q | mism_vec;
      err_count_d  = err_count_q;
      if (any_mism && (err_count_q != 4'hF)) begin
         err_count_d = err_count_q + 4'd1;
      end
      fail_seen_d  = fail_seen_q | any_mism;
      first_fail_d = first_fail_q;
      if (any_mism && !fail_seen_q) begin
         first_fail_d = {a_q, b_q};
      end
      ident_err_d  = ident_err_q | ident_bad;
   end

   // Sequencer, stimulus registers and sticky status
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         vec_q        <= 2'd0;
         pass_cnt_q   <= 3'd0;
         settle_q     <= 4'd0;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_mask_q   <= 8'd0;
         err_count_q  <= 4'd0;
         first_fail_q <= 2'd0;
         fail_seen_q  <= 1'b0;
         ident_err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  vec_q        <= 2'd0;
                  pass_cnt_q   <= 3'd0;
                  a_q          <= 1'b0;
                  b_q          <= 1'b0;
                  busy_q       <= 1'b1;
                  pass_q       <= 1'b0;
                  err_mask_q   <= 8'd0;
                  err_count_q  <= 4'd0;
                  first_fail_q <= 2'd0;
                  fail_seen_q  <= 1'b0;
                  ident_err_q  <= 1'b0;
                  state_q      <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (SETTLE_CYCLES == 0) begin
                  state_q <= ST_CHECK;
               end else begin
                  settle_q <= SETTLE_LD;
                  state_q  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_q == 4'd0) begin
                  state_q <= ST_CHECK;
               end else begin
                  settle_q <= settle_q - 4'd1;
               end
            end
            ST_CHECK: begin
               err_mask_q   <= err_mask_d;
               err_count_q  <= err_count_d;
               first_fail_q <= first_fail_d;
               fail_seen_q  <= fail_seen_d;
               ident_err_q  <= ident_err_d;
               if (vec_q != 2'd3) begin
                  vec_q   <= vec_nxt;
                  a_q     <= vec_nxt[1];
                  b_q     <= vec_nxt[0];
                  state_q <= ST_DRIVE;
               end else if (pass_cnt_q != PASS_LAST) begin
                  vec_q      <= 2'd0;
                  pass_cnt_q <= pass_cnt_q + 3'd1;
                  a_q        <= 1'b0;
                  b_q        <= 1'b0;
                  state_q    <= ST_DRIVE;
               end else begin
                  // A/B deliberately left at {1,1} for inspection after the run
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= ~(fail_seen_d | ident_err_d);
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign gate_if.A  = a_q;
   assign gate_if.B  = b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_mask   = err_mask_q;
   assign err_count  = err_count_q;
   assign first_fail = first_fail_q;
   assign fail_seen  = fail_seen_q;
   assign ident_err  = ident_err_q;

endmodule

// File: tb/tb_demorgan_checker.sv
// Bench for demorgan_checker: three instances (settle/passes 2/1, 2/8, 0/1) each driving a gate-block model with selectable fault.
// Latency: checks done timing against start+1+PASSES*4*(SETTLE+2).
// Backpressure: exercises ignored start pulses mid-run and in DONE.
module tb_demorgan_checker;

   localparam int SET_TBL [3] = '{2, 2, 0};
   localparam int PAS_TBL [3] = '{1, 8, 1};

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] start_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [2:0] pass_v;
   logic [2:0] fail_v;
   logic [2:0] ident_v;
   logic [7:0] mask_v [3];
   logic [3:0] cnt_v  [3];
   logic [1:0] ff_v   [3];
   logic [1:0] ab_v   [3];
   int         fault_mode [3];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate block under test: 0 clean, 1 AB stuck 0, 2 nAorB wired to AorB, 3 nA wired to A
   function automatic logic [7:0] gate_model(input logic a, input logic b, input int mode);
      logic [7:0] v;
      v[0] = ~a;
      v[1] = ~b;
      v[2] = a & b;
      v[3] = a | b;
      v[4] = ~a & ~b;
      v[5] = ~(a | b);
      v[6] = ~a | ~b;
      v[7] = ~(a & b);
      if (mode == 1) v[2] = 1'b0;
      if (mode == 2) v[5] = a | b;
      if (mode == 3) v[0] = a;
      return v;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      demorgan_if gif ();
      logic [7:0] gv;
      assign gv          = gate_model(gif.A, gif.B, fault_mode[g]);
      assign gif.nA      = gv[0];
      assign gif.nB      = gv[1];
      assign gif.AB      = gv[2];
      assign gif.AorB    = gv[3];
      assign gif.nAandnB = gv[4];
      assign gif.nAorB   = gv[5];
      assign gif.nAornB  = gv[6];
      assign gif.nAB     = gv[7];
      assign ab_v[g]     = {gif.A, gif.B};

      demorgan_checker #(
         .SETTLE_CYCLES (SET_TBL[g]),
         .PASSES        (PAS_TBL[g])
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .start      (start_v[g]),
         .gate_if    (gif),
         .busy       (busy_v[g]),
         .done       (done_v[g]),
         .pass       (pass_v[g]),
         .err_mask   (mask_v[g]),
         .err_count  (cnt_v[g]),
         .first_fail (ff_v[g]),
         .fail_seen  (fail_v[g]),
         .ident_err  (ident_v[g])
      );
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_status(input int i, input string tag, input logic pass_e,
                             input logic [7:0] mask_e, input logic [3:0] cnt_e,
                             input logic [1:0] ff_e, input logic fs_e, input logic id_e);
      chk_eq({tag, ".busy"},  32'(busy_v[i]),  32'd0);
      chk_eq({tag, ".pass"},  32'(pass_v[i]),  32'(pass_e));
      chk_eq({tag, ".mask"},  32'(mask_v[i]),  32'(mask_e));
      chk_eq({tag, ".cnt"},   32'(cnt_v[i]),   32'(cnt_e));
      chk_eq({tag, ".ffail"}, 32'(ff_v[i]),    32'(ff_e));
      chk_eq({tag, ".fseen"}, 32'(fail_v[i]),  32'(fs_e));
      chk_eq({tag, ".ident"}, 32'(ident_v[i]), 32'(id_e));
   endtask

   // One run: start pulse, then watch latency, single done, A/B sequence and busy
   task automatic do_run(input int i, input int lat, input bit inject, input string tag);
      int t0;
      int off;
      int tdone;
      int ndone;
      int bad;
      int s;
      int exp_ab;
      s = SET_TBL[i];
      @(posedge clk); #1;
      start_v[i] = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      tdone = -1;
      ndone = 0;
      bad   = 0;
      for (int k = 0; k < lat + 20; k++) begin
         @(negedge clk);
         off = cyc - t0;
         if (done_v[i] === 1'b1) begin
            ndone++;
            if (tdone < 0) tdone = off;
         end
         if (off >= 1 && off < lat) begin
            exp_ab = ((off - 1) / (s + 2)) % 4;
            if (busy_v[i] !== 1'b1 || ab_v[i] !== 2'(exp_ab)) bad++;
         end
         start_v[i] = inject && (off == 3 || off == 40 || off == 77 || off == lat);
      end
      start_v[i] = 1'b0;
      chk_eq({tag, ".latency"}, 32'(tdone), 32'(lat));
      chk_eq({tag, ".ndone"},   32'(ndone), 32'd1);
      chk_eq({tag, ".trace"},   32'(bad),   32'd0);
      chk_eq({tag, ".ab_end"},  32'(ab_v[i]), 32'd3);
   endtask

   initial begin
      int t0;
      int ndone;
      reset      = 1'b1;
      start_v    = '0;
      fault_mode = '{0, 0, 0};
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_eq("rst.done", 32'(done_v[0]), 32'd0);
      chk_eq("rst.ab",   32'(ab_v[0]),   32'd0);
      chk_status(0, "rst", 1'b0, 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);

      // Clean gate block, settle 2, one pass
      do_run(0, 17, 1'b0, "s1");
      chk_status(0, "s1", 1'b1, 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);

      // AB stuck at 0: only vector 11 fails
      fault_mode[0] = 1;
      do_run(0, 17, 1'b0, "s2");
      chk_status(0, "s2", 1'b0, 8'h04, 4'd1, 2'b11, 1'b1, 1'b0);

      // nAorB wired to AorB: every vector fails and the identity breaks
      fault_mode[0] = 2;
      do_run(0, 17, 1'b0, "s3");
      chk_status(0, "s3", 1'b0, 8'h20, 4'd4, 2'b00, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      chk_status(0, "s3hold", 1'b0, 8'h20, 4'd4, 2'b00, 1'b1, 1'b1);

      // Reset in cycle 6 of a faulty run
      @(posedge clk); #1;
      start_v[0] = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_eq("s4.cycle",    32'(cyc - t0),   32'd6);
      chk_eq("s4.pre_busy", 32'(busy_v[0]),  32'd1);
      chk_eq("s4.pre_fail", 32'(fail_v[0]),  32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk_eq("s4.ab",   32'(ab_v[0]),   32'd0);
      chk_eq("s4.done", 32'(done_v[0]), 32'd0);
      chk_status(0, "s4rst", 1'b0, 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);
      ndone = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) ndone++;
      end
      chk_eq("s4.no_done", 32'(ndone), 32'd0);
      fault_mode[0] = 0;
      do_run(0, 17, 1'b0, "s4run");
      chk_status(0, "s4run", 1'b1, 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);

      // Eight passes with nA wrong, start pulses injected mid-run and in DONE
      fault_mode[1] = 3;
      do_run(1, 129, 1'b1, "s5");
      chk_status(1, "s5", 1'b0, 8'h01, 4'd15, 2'b00, 1'b1, 1'b0);

      // Zero settle cycles, clean gate block
      do_run(2, 9, 1'b0, "s6");
      chk_status(2, "s6", 1'b1, 8'h00, 4'd0, 2'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
